// File: rtl/pipeline_register_hs_pkg.sv
// Shared defaults and helpers for the elastic pipeline register.
// Optional skid entry is selected with PIPELINE_REG_SKID_EN.
package pipeline_register_hs_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 1;

`ifdef PIPELINE_REG_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Counts 0..DEPTH+1 so the skid entry fits too.
  function automatic int occ_width(input int depth);
    return clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipeline_register_hs_if.sv
// Valid/ready/data handshake bundle.
// master drives valid and data, slave drives ready.
interface pipeline_register_hs_if #(
  parameter int WIDTH = 32
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipeline_slot.sv
// One valid+data register with enable and clear.
// Data only loads when the incoming beat is valid.
module pipeline_slot
  import pipeline_register_hs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Capture source beat; clear wins over load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= 1'b0;
      d <= '0;
    end else if (clr) begin
      v <= 1'b0;
    end else if (en) begin
      v <= src_v;
      if (src_v) d <= src_d;
    end
  end

endmodule

// File: rtl/pipeline_register_hs.sv
// DEPTH-stage elastic pipeline with stall, flush and bubble collapse.
// Define PIPELINE_REG_SKID_EN to add a skid entry and register in_ready.
module pipeline_register_hs
  import pipeline_register_hs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    stall,
  pipeline_register_hs_if.slave   in_if,
  pipeline_register_hs_if.master  out_if,
  output logic [OCC_W-1:0]        occupancy
);

  logic             hold;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             head_v;
  logic [WIDTH-1:0] head_d;
  logic             in_rdy;
  logic             in_xfer;
  logic             out_xfer;

  assign hold = stall | flush;

  // Enable chain from the output side; an empty stage always loads.
  always_comb begin
    en = '0;
    en[DEPTH-1] = (out_if.ready | ~v[DEPTH-1]) & ~hold;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      en[i] = (~v[i] | en[i+1]) & ~hold;
    end
  end

  // Each stage sources from its predecessor, stage 0 from the head.
  always_comb begin
    src_v = '0;
    src_v[0] = head_v;
    src_d[0] = head_d;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipeline_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .en    (en[g]),
      .clr   (flush),
      .src_v (src_v[g]),
      .src_d (src_d[g]),
      .v     (v[g]),
      .d     (d[g])
    );
  end

`ifdef PIPELINE_REG_SKID_EN
  logic             sv;
  logic [WIDTH-1:0] sd;
  logic             skid_en;

  // Ready comes straight off the skid flop, cutting the
  // combinational path back from out_ready.
  assign in_rdy  = ~sv & ~hold;
  assign head_v  = sv | in_xfer;
  assign head_d  = sv ? sd : in_if.data;
  assign skid_en = sv ? en[0] : (in_xfer & ~en[0]);

  pipeline_slot #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .clr   (flush),
    .src_v (~sv),
    .src_d (in_if.data),
    .v     (sv),
    .d     (sd)
  );
`else
  // Timing: in_ready is combinational from out_ready through
  // the whole enable chain (DEPTH levels).
  assign in_rdy = en[0];
  assign head_v = in_if.valid;
  assign head_d = in_if.data;
`endif

  assign in_if.ready  = in_rdy;
  assign in_xfer      = in_if.valid & in_rdy;
  assign out_if.valid = v[DEPTH-1] & ~hold;
  assign out_if.data  = d[DEPTH-1];
  assign out_xfer     = out_if.valid & out_if.ready;

  // Occupancy tracks transfers on both sides; flush empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy
                 + OCC_W'(in_xfer)
                 - OCC_W'(out_xfer);
    end
  end

endmodule

// File: tb/tb_pipeline_register_hs.sv
// Scoreboard bench for pipeline_register_hs at DEPTH=3.
// Works with or without PIPELINE_REG_SKID_EN.
module tb_pipeline_register_hs;
  import pipeline_register_hs_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 3;
  localparam int CAP   = DEPTH + (SKID_EN ? 1 : 0);
  localparam int OW    = occ_width(DEPTH);

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    bit           lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic [OW-1:0] occ;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  exp_t          exp_q[$];

  pipeline_register_hs_if #(.WIDTH(W)) in_if ();
  pipeline_register_hs_if #(.WIDTH(W)) out_if ();

  pipeline_register_hs #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .in_if     (in_if),
    .out_if    (out_if),
    .occupancy (occ)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Monitor: pop and compare on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_out: got %h want none",
                 out_if.data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_if.data, e.data);
        if (e.lat) chk("latency", W'(cyc - e.cyc), W'(DEPTH));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] dat,
                      input bit rdy,
                      input bit lat);
    in_if.valid = 1'b1;
    in_if.data  = dat;
    @(negedge clk);
    chk("in_ready", W'(in_if.ready), W'(rdy));
    if (in_if.ready) exp_q.push_back('{dat, cyc, lat});
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(1);
    chk("drain_done", W'(exp_q.size()), 0);
    @(negedge clk);
    chk("occ_empty", W'(occ), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", W'(out_if.valid), 0);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_occ", W'(occ), 0);
    chk("rst_in_ready", W'(in_if.ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);

    // Back-to-back stream, DEPTH-cycle latency.
    send(32'h11, 1'b1, 1'b1);
    send(32'h22, 1'b1, 1'b1);
    send(32'h33, 1'b1, 1'b1);
    drain();

    // Fill with backpressure, then one beyond capacity.
    out_if.ready = 1'b0;
    for (int i = 0; i <= CAP; i++)
      send(32'hA1 + W'(i), i < CAP, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("full_occ", W'(occ), W'(CAP));
      chk("full_valid", W'(out_if.valid), 1);
      chk("full_data", out_if.data, 32'hA1);
      chk("full_ready", W'(in_if.ready), 0);
      @(posedge clk);
      #1;
    end
    drain();

    // Bubble collapse behind a blocked output.
    out_if.ready = 1'b0;
    send(32'h5, 1'b1, 1'b0);
    tick(2);
    @(negedge clk);
    chk("bub_valid", W'(out_if.valid), 1);
    chk("bub_data", out_if.data, 32'h5);
    chk("bub_occ1", W'(occ), 1);
    @(posedge clk);
    #1;
    send(32'h6, 1'b1, 1'b0);
    send(32'h7, 1'b1, 1'b0);
    @(negedge clk);
    chk("bub_occ3", W'(occ), 3);
    @(posedge clk);
    #1;
    drain();

    // Two-cycle stall mid-stream.
    send(32'h41, 1'b1, 1'b0);
    send(32'h42, 1'b1, 1'b0);
    send(32'h43, 1'b1, 1'b0);
    stall       = 1'b1;
    in_if.valid = 1'b1;
    in_if.data  = 32'h44;
    repeat (2) begin
      @(negedge clk);
      chk("stl_in_ready", W'(in_if.ready), 0);
      chk("stl_out_valid", W'(out_if.valid), 0);
      chk("stl_out_data", out_if.data, 32'h41);
      chk("stl_occ", W'(occ), 3);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    send(32'h44, 1'b1, 1'b0);
    send(32'h45, 1'b1, 1'b0);
    send(32'h46, 1'b1, 1'b0);
    drain();

    // Flush with two beats held and input valid.
    out_if.ready = 1'b0;
    send(32'h51, 1'b1, 1'b0);
    send(32'h52, 1'b1, 1'b0);
    tick(1);
    flush       = 1'b1;
    in_if.valid = 1'b1;
    in_if.data  = 32'h5F;
    @(negedge clk);
    chk("fl_in_ready", W'(in_if.ready), 0);
    chk("fl_out_valid", W'(out_if.valid), 0);
    chk("fl_occ_pre", W'(occ), 2);
    @(posedge clk);
    exp_q.delete();
    #1;
    flush       = 1'b0;
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("fl_occ_post", W'(occ), 0);
    chk("fl_valid_post", W'(out_if.valid), 0);
    @(posedge clk);
    #1;
    out_if.ready = 1'b1;
    send(32'h9, 1'b1, 1'b1);
    drain();

    // Asynchronous reset while full.
    out_if.ready = 1'b0;
    for (int i = 0; i < CAP; i++)
      send(32'h61 + W'(i), 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_rst_occ", W'(occ), W'(CAP));
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_out_valid", W'(out_if.valid), 0);
    chk("ar_out_data", out_if.data, 0);
    chk("ar_occ", W'(occ), 0);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    out_if.ready = 1'b1;
    tick(5);
    @(negedge clk);
    chk("post_rst_occ", W'(occ), 0);
    chk("q_left", W'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_register_hs.md
Name: pipeline_register_hs

Overview:
- Parametrised successor to the plain pipeline register: a DEPTH-stage elastic pipeline carrying WIDTH-bit payload with per-stage valid bits.
- Adds a valid/ready handshake, bubble collapsing, global stall and synchronous flush.
- Sits between CPU pipeline stages, e.g. IF/ID and ID/EX, where hazard logic needs stall and flush rather than an unconditional capture every cycle.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 1, number of register stages (>=1); stage 0 is input side, stage DEPTH-1 is output side.
- OCC_W, $clog2(DEPTH+2), width of the occupancy output. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- flush  input  1  synchronous flush; discards all held beats.
- stall  input  1  global freeze of all stages.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  output payload; equals stage DEPTH-1 data.
- occupancy  output  OCC_W  number of valid entries held (stages plus skid).

Behaviour:
- Reset (reset low, asynchronous): all stage valids=0 and all data registers=0 (skid too, when present). out_valid=0, out_data=0, occupancy=0. in_ready follows the combinational rules below.
- Per-stage enable, chained from the output side:
  - en[DEPTH-1] = (out_ready | ~v[DEPTH-1]) & ~stall & ~flush
  - en[i] = (~v[i] | en[i+1]) & ~stall & ~flush
- Bubble collapsing follows from this chain: an empty stage always loads, even when later stages are blocked.
- On en[i], v[i] <= valid of the source. The source is stage i-1, or the input for stage 0.
- d[i] loads only when en[i] and the source is valid; otherwise d[i] holds.
- Without the skid feature: in_ready = en[0]. This is a combinational path from out_ready; document it for timing.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid = v[DEPTH-1] & ~stall & ~flush.
  - out_data is always d[DEPTH-1], even while gated.
- Latency: with no backpressure an accepted beat appears at the output DEPTH cycles later. Throughput is 1 beat/cycle. Capacity is DEPTH beats.
- Stall: all valid and data registers hold. in_ready=0 and out_valid=0 for that cycle, so no transfer occurs on either side.
- Flush: next edge clears every valid (and the skid). Within the flush cycle in_ready=0 and out_valid=0. Priority order is reset > flush > stall > normal.
- Full with out_ready=0: in_ready=0 and contents are stable.
- Full with out_ready=1: simultaneous in and out transfer; occupancy is unchanged.
- occupancy is a registered count: +1 on input transfer, -1 on output transfer, 0 on flush. It must equal the popcount of the valids (plus the skid valid).
- Reset asserted mid-stream: all beats are dropped immediately. No output transfer occurs until a new beat has traversed DEPTH stages.

Optional Feature:
- Macro PIPELINE_REG_SKID_EN.
- Defined: adds a one-entry skid register (sv, sd) in front of stage 0.
  - in_ready = ~sv, driven from a register, with no combinational path from out_ready.
  - When the skid is empty, accepted beats go to stage 0 if en[0]; otherwise they go to the skid.
  - When sv=1, stage 0 sources from the skid, and sv clears when en[0].
  - Capacity is DEPTH+1. Latency is DEPTH while the skid is empty.
  - Stall and flush rules apply to the skid: stall holds it, flush clears it. in_ready stays ~sv & ~flush & ~stall.
- Undefined: no skid; in_ready is combinational as above; OCC_W is unchanged.

Decomposition:
- Shared header pipeline_defs.vh holds:
  - default WIDTH (32);
  - the PIPELINE_REG_SKID_EN switch;
  - a clog2 helper for OCC_W.
- One natural sub-module, pipeline_slot: a single valid+data register with en and clr, asynchronous active-low reset, and load-data-only-when-source-valid.
  - It is instantiated DEPTH times by a generate loop, plus once for the skid.

Test Plan:
- DEPTH=3, out_ready=1, inject 0x11,0x22,0x33 on consecutive cycles -> the same sequence appears on out_data, each beat 3 cycles after its input, back-to-back.
- DEPTH=3, out_ready=0, push 4 beats -> 3 accepted, in_ready=0 on the 4th, occupancy=3. Raise out_ready -> 0xA1,0xA2,0xA3 drain in order with no loss or duplication.
- Bubble collapse: DEPTH=3, a single beat 0x5 with out_ready=0 -> it reaches stage 2 after 3 cycles. Push 0x6, 0x7 -> both accepted, occupancy=3.
- stall held 2 cycles mid-stream with out_ready=1 -> in_ready=0 and out_valid=0 during the stall, contents frozen, and the sequence resumes unchanged afterwards.
- flush pulsed with 2 beats held and in_valid=1 -> no transfers that cycle, then occupancy=0 and out_valid=0. The next accepted beat 0x9 emerges after DEPTH cycles.
- reset driven low asynchronously while full -> out_valid=0, out_data=0, occupancy=0 immediately. With PIPELINE_REG_SKID_EN, a full pipe plus skid reports occupancy=DEPTH+1 before the reset.
